// File: rtl/level_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : level_timer_ctrl
// Brief    : Per-level countdown timer with BCD digits, pause and bonus time.
// Revision : 1.0
// ============================================================================
module level_timer_ctrl #(
   parameter int TICK_DIV   = 31_500_000,
   parameter int LEVEL_TIME = 60,
   parameter int LOW_TIME   = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_level,
   input  logic       pause,
   input  logic       add_bonus,
   input  logic [3:0] bonus_secs,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic       one_sec,
   output logic       timer_running,
   output logic       timer_ended,
   output logic       low_time
);

   localparam int            PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] c_PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [3:0]    c_LT_TENS   = 4'(LEVEL_TIME / 10);
   localparam logic [3:0]    c_LT_ONES   = 4'(LEVEL_TIME % 10);
   localparam logic          c_LT_LOW    = (LEVEL_TIME <= LOW_TIME) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_presc;
   logic [3:0]    r_tens;
   logic [3:0]    r_ones;
   logic          r_one_sec;
   logic          r_ended;
   logic          r_running;
   logic          r_low;

   logic [6:0]    w_time;
   logic          w_tick;
   logic [7:0]    w_raw;
   logic [6:0]    w_new;

   function automatic logic [7:0] f_bcd(input logic [6:0] v);
      logic [3:0] t;
      t = 4'd0;
      for (int k = 1; k < 10; k++)
         if (v >= 7'(k * 10)) t = 4'(k);
      return {t, 4'(v - 7'(t) * 7'd10)};
   endfunction

   function automatic logic f_low(input logic [6:0] v);
      return (v != 7'd0) && (v <= 7'(LOW_TIME));
   endfunction

   // Tick, bonus and saturation folded into one binary sum so the
   // simultaneous tick+bonus case falls out without extra cases.
   assign w_time = 7'(r_tens) * 7'd10 + 7'(r_ones);
   assign w_tick = (r_state == S_RUN) && (r_presc == c_PRESC_MAX) && !pause;
   assign w_raw  = {1'b0, w_time} - {7'd0, w_tick} + (add_bonus ? {4'd0, bonus_secs} : 8'd0);
   assign w_new  = (w_raw > 8'd99) ? 7'd99 : w_raw[6:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_presc   <= '0;
         r_tens    <= 4'd0;
         r_ones    <= 4'd0;
         r_one_sec <= 1'b0;
         r_ended   <= 1'b0;
         r_running <= 1'b0;
         r_low     <= 1'b0;
      end else begin
         r_one_sec <= 1'b0;
         r_ended   <= 1'b0;
         if (start_level) begin
            r_state   <= S_RUN;
            r_presc   <= '0;
            r_tens    <= c_LT_TENS;
            r_ones    <= c_LT_ONES;
            r_running <= 1'b1;
            r_low     <= c_LT_LOW;
         end else begin
            case (r_state)
               S_RUN: begin
                  {r_tens, r_ones} <= f_bcd(w_new);
                  r_low            <= f_low(w_new);
                  if (pause) begin
                     // Entering PAUSE freezes the prescaler and drops any tick.
                     r_state   <= S_PAUSE;
                     r_running <= 1'b0;
                  end else if (w_tick) begin
                     r_presc   <= '0;
                     r_one_sec <= 1'b1;
                     if (w_new == 7'd0) begin
                        r_state   <= S_DONE;
                        r_running <= 1'b0;
                        r_ended   <= 1'b1;
                     end
                  end else begin
                     r_presc <= r_presc + PW'(1);
                  end
               end
               S_PAUSE: begin
                  {r_tens, r_ones} <= f_bcd(w_new);
                  r_low            <= f_low(w_new);
                  if (!pause) begin
                     r_state   <= S_RUN;
                     r_running <= 1'b1;
                  end
               end
               S_IDLE, S_DONE: ;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign ones          = r_ones;
   assign tens          = r_tens;
   assign one_sec       = r_one_sec;
   assign timer_running = r_running;
   assign timer_ended   = r_ended;
   assign low_time      = r_low;

endmodule
`default_nettype wire

// File: doc/level_timer_ctrl.md
LEVEL_TIMER_CTRL -- requirements
Module: level_timer_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 31_500_000: clk cycles per one-second tick; legal range 2 and above.
REQ-002 Parameter LEVEL_TIME, default 60: per-level start time in seconds; legal range 1..99.
REQ-003 Parameter LOW_TIME, default 10: seconds threshold for the low-time warning.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port start_level, input, 1: one-cycle pulse that loads LEVEL_TIME and starts the countdown.
REQ-007 Port pause, input, 1: level signal; while high, the countdown is frozen.
REQ-008 Port add_bonus, input, 1: one-cycle pulse that adds bonus_secs to the remaining time.
REQ-009 Port bonus_secs, input, 4: unsigned binary bonus in seconds, 0..15.
REQ-010 Port ones, output, 4: BCD units digit of the remaining seconds, 0..9.
REQ-011 Port tens, output, 4: BCD tens digit of the remaining seconds, 0..9.
REQ-012 Port one_sec, output, 1: one-cycle pulse on each counted second.
REQ-013 Port timer_running, output, 1: high in RUN state only.
REQ-014 Port timer_ended, output, 1: one-cycle pulse when the time reaches 00.
REQ-015 Port low_time, output, 1: warning when the time is at or below LOW_TIME.

Function
REQ-016 The block SHALL implement the states IDLE, RUN, PAUSE and DONE, all of them registered.
REQ-017 start_level SHALL take priority in every state: on the next edge, {tens,ones} = LEVEL_TIME in BCD, prescaler = 0, state = RUN.
REQ-018 RUN SHALL go to PAUSE on an edge where pause=1 and start_level=0; PAUSE SHALL return to RUN on an edge where pause=0.
REQ-019 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, hold its value in PAUSE, and read 0 in IDLE and DONE.
REQ-020 On the RUN edge where the prescaler equals TICK_DIV-1, the block SHALL wrap the prescaler to 0, pulse one_sec in the following cycle, and decrement the time by 1.
REQ-021 The BCD decrement SHALL work as follows: if ones>0, ones-1; otherwise ones=9 and tens-1. Every digit SHALL always stay within 0..9.
REQ-022 When a decrement yields 00, the block SHALL enter DONE on that edge and assert timer_ended for exactly the following cycle.
REQ-023 DONE SHALL hold the value 00 and SHALL ignore pause, add_bonus and the prescaler; only start_level or reset leaves DONE.
REQ-024 add_bonus SHALL act in RUN or PAUSE only and set the time to min(time + bonus_secs, 99), with the result in BCD.
REQ-025 add_bonus SHALL be ignored in IDLE and DONE.
REQ-026 When a tick and add_bonus fall on the same edge, the new time SHALL be min(time - 1 + bonus_secs, 99).
REQ-027 In the simultaneous case, DONE SHALL be entered only if that combined result is 00.
REQ-028 When pause=1 coincides with a tick edge in RUN, the block SHALL enter PAUSE and SHALL NOT apply the decrement.
REQ-029 low_time SHALL equal (state is RUN or PAUSE) and (time <= LOW_TIME) and (time != 0).
REQ-030 timer_running, timer_ended, one_sec and low_time SHALL be registered outputs.
REQ-031 No output SHALL glitch on an input that arrives between clock edges.

Reset
REQ-032 While reset=1, asynchronously: state = IDLE, prescaler = 0, ones = 0, tens = 0, and one_sec, timer_ended, timer_running and low_time all = 0.
REQ-033 Reset asserted in the middle of a countdown SHALL abort it; after release, the block SHALL stay in IDLE until start_level.
REQ-034 The outputs SHALL read 00 while the block idles.

Verification (TICK_DIV=4, LEVEL_TIME=12, LOW_TIME=10)
REQ-035 start_level pulse, then 48 cycles -> 12 one_sec pulses spaced 4 cycles apart; value sequence 12,11,10,09,...,01,00; one timer_ended pulse; state DONE; no further pulses.
REQ-036 pause=1 for 10 cycles starting at value 11 -> value holds at 11, timer_running=0, prescaler holds; after release, the next tick arrives at the remaining prescaler count.
REQ-037 At value 97 in RUN, add_bonus with bonus_secs=5 -> value 99 (saturated). At value 03, add_bonus with bonus_secs=4 on a tick edge -> value 06, no end.
REQ-038 At value 01, a tick coinciding with add_bonus and bonus_secs=0 -> value 00, DONE, timer_ended pulse. In DONE, add_bonus -> no change.
REQ-039 Decrement from 10 -> value 09 (ones wraps to 9, tens becomes 0); low_time=1 at 10 and at 09, and 0 at 00.
REQ-040 Reset asserted at value 07 in RUN -> all outputs 0 immediately. start_level asserted in DONE -> value 12 and RUN on the next edge.
